// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and default sizes for the fetch-to-decode instruction queue.
package ifq_pkg;

    localparam int IFQ_DEPTH = 4;
    localparam int IFQ_AW    = 64;
    localparam int IFQ_IW    = 32;

    // One queued fetch result at the default address/instruction widths.
    typedef struct packed {
        logic [IFQ_AW-1:0] pc;
        logic [IFQ_IW-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ptr.sv
// ifq_ptr: wrap-around queue pointer with async active-low reset,
// synchronous clear and increment enable. Wraps naturally at 2**W.
module ifq_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Pointer register: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= {W{1'b0}};
        end else if (clr) begin
            ptr <= {W{1'b0}};
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/ifid_queue.sv
// ifid_queue: FIFO of {PC, instruction} pairs between fetch and decode.
// Optional feature macro: IFQ_BYPASS_EN (empty-queue fall-through from fetch
// to decode in the same cycle). Without it, a push is visible one cycle later.
module ifid_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int AW    = IFQ_AW,
    parameter int IW    = IFQ_IW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_F,
    input  logic [AW-1:0]          pc_F,
    input  logic [IW-1:0]          instr_F,
    output logic                   ready_F,
    output logic                   valid_D,
    output logic [AW-1:0]          pc_D,
    output logic [IW-1:0]          instr_D,
    input  logic                   pop_D,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } entry_t;

    // Storage is deliberately not reset; valid_D gates its visibility.
    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic flush_eff;
    logic empty;
    logic byp;
    logic byp_pop;
    logic push_fire;
    logic pop_fire;
    logic wr_inc;
    logic rd_inc;

    // Flush means nothing while reset is asserted.
    assign flush_eff = flush & reset;
    assign empty     = (count == CW'(0));

`ifdef IFQ_BYPASS_EN
    assign byp = reset & ~flush & empty & push_F;
`else
    assign byp = 1'b0;
`endif

    // A full queue refuses pushes even if decode pops this cycle, so ready_F
    // never depends on pop_D.
    assign ready_F   = ~flush_eff & (count < CW'(DEPTH));
    assign push_fire = push_F & ready_F;
    assign pop_fire  = valid_D & pop_D;
    // A bypassed entry consumed in the same cycle is never stored.
    assign byp_pop   = byp & pop_D;
    assign wr_inc    = push_fire & ~byp_pop;
    assign rd_inc    = pop_fire & ~byp_pop;

    // Head presentation: stored head first, fetch fall-through when empty, else zero.
    always_comb begin
        valid_D = 1'b0;
        pc_D    = {AW{1'b0}};
        instr_D = {IW{1'b0}};
        if (flush_eff) begin
            valid_D = 1'b0;
        end else if (!empty) begin
            valid_D = 1'b1;
            pc_D    = mem[rd_ptr].pc;
            instr_D = mem[rd_ptr].instr;
        end else if (byp) begin
            valid_D = 1'b1;
            pc_D    = pc_F;
            instr_D = instr_F;
        end else begin
            valid_D = 1'b0;
        end
    end

    ifq_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset),
        .clr   (flush_eff),
        .inc   (wr_inc),
        .ptr   (wr_ptr)
    );

    ifq_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset),
        .clr   (flush_eff),
        .inc   (rd_inc),
        .ptr   (rd_ptr)
    );

    // Entry write at the write pointer on an accepted, stored push.
    always_ff @(posedge clk) begin
        if (wr_inc && !flush_eff) begin
            mem[wr_ptr] <= '{pc: pc_F, instr: instr_F};
        end else begin
            mem[wr_ptr] <= mem[wr_ptr];
        end
    end

    // Occupancy counter: flush clears, simultaneous push and pop hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= CW'(0);
        end else if (flush_eff) begin
            count <= CW'(0);
        end else begin
            case ({wr_inc, rd_inc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Instruction queue between the fetch stage and decode in the 64-bit pipelined processor. Captures each fetched {PC, instruction} pair into a small FIFO so that a decode stall does not stall fetch immediately, and presents the oldest entry to decode with a valid/ready handshake. A flush (taken branch or exception redirect) discards every queued instruction in one cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- AW, 64, PC width
- IW, 32, instruction width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- push_F  input  1  fetch presents a valid instruction this cycle
- pc_F  input  AW  PC of the presented instruction (imem_addr_F)
- instr_F  input  IW  instruction word from instruction memory
- ready_F  output  1  queue accepts a push this cycle
- valid_D  output  1  pc_D/instr_D hold a valid instruction
- pc_D  output  AW  PC of the oldest entry
- instr_D  output  IW  instruction of the oldest entry
- pop_D  input  1  decode consumes the head entry this cycle
- flush  input  1  discard all entries (PCSrc or EProc redirect)
- count  output  $clog2(DEPTH)+1  number of stored entries

## Operation
- Push fires when push_F && ready_F; pop fires when valid_D && pop_D.
- ready_F = (count < DEPTH); full queue rejects a push even if a pop fires the same cycle.
- Push writes the entry at the write pointer and increments it; pop increments the read pointer; pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- pop_D with valid_D=0 is ignored; push_F with ready_F=0 is dropped (fetch must hold PC).
- pc_D and instr_D read 0 whenever valid_D=0; storage itself is not reset.
- flush: highest priority; at the next edge count=0 and both pointers=0; a push or pop in the flush cycle has no effect on state. While flush=1, valid_D is forced 0 and ready_F is forced 0.
- Reset asserted (reset=0), at any time including mid-operation: pointers 0, count 0, valid_D 0, pc_D 0, instr_D 0, ready_F 1. Flush input is ignored during reset.

## Timing
- Without bypass: push at edge N makes valid_D=1 from N onward (one-cycle latency from push_F to valid_D).
- Pop is combinational from head: after a pop at edge N, the next entry (if any) is visible immediately after N.
- ready_F, valid_D and count are derived from registered state only (plus flush and bypass path); no path from pop_D to ready_F.
- Throughput: one push and one pop per cycle.

## Configuration
- IFQ_BYPASS_EN defined: when count=0 and push_F=1 (no flush), valid_D=1 in the same cycle with pc_D=pc_F, instr_D=instr_F; if pop_D=1 that cycle the entry is consumed and not written (count stays 0); otherwise it is written normally. Adds a combinational path push_F/pc_F/instr_F to decode.
- Undefined: no fall-through; minimum latency one cycle as in Timing.

## Structure
- Package ifq_pkg: typedef ifq_entry_t (struct of pc [AW-1:0], instr [IW-1:0]); localparam defaults IFQ_DEPTH=4, IFQ_AW=64, IFQ_IW=32.
- Sub-module ifq_ptr: wrap-around pointer register with async active-low reset, synchronous clear (flush) and increment enable; instantiated for read and write pointers.
- Storage array and count register live in ifid_queue.

## Test plan
- Reset then push pc_F=0x0,0x4,0x8,0xC with pop_D=0 -> count=4, ready_F=0, valid_D=1, pc_D=0x0; fifth push at 0x10 dropped.
- Full queue, then pop_D=1 for four cycles -> pc_D sequence 0x0,0x4,0x8,0xC, then valid_D=0, pc_D=0, count=0.
- Steady push and pop every cycle from PC 0x100 for 12 cycles -> count stays 1 (0 with IFQ_BYPASS_EN), pointers wrap, pc_D increments by 4 in order with no gaps.
- Three entries queued, flush=1 with push_F=1 at 0xD8 -> next cycle count=0, valid_D=0; push 0xD8 following cycle -> pc_D=0xD8.
- Two entries queued, reset driven to 0 mid-cycle -> outputs immediately valid_D=0, count=0, ready_F=1 without waiting for a clock edge.
- IFQ_BYPASS_EN defined, empty queue, push 0x200 instr 0x8B020020 with pop_D=1 -> valid_D=1, pc_D=0x200, instr_D=0x8B020020 same cycle; count remains 0.
